// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: FSM states, full-adder cell I/O structs
// and the default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic cin;
  } cell_in_t;

  typedef struct packed {
    logic sum;
    logic carry;
  } cell_out_t;

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder operating on the package cell structs.
module fa_cell
  import serial_add_pkg::*;
(
  input  cell_in_t  cell_in,
  output cell_out_t cell_out
);

  assign cell_out.sum   = cell_in.a ^ cell_in.b ^ cell_in.cin;
  assign cell_out.carry = (cell_in.a & cell_in.b) | (cell_in.cin & (cell_in.a ^ cell_in.b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell adds two WIDTH-bit operands LSB-first.
// Optional signed-overflow output out_ovf is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             out_ovf,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  cell_in_t         cell_in;
  cell_out_t        cell_out;

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB, captured while the last bit is being added.
  logic msb_cin;
  assign out_ovf = msb_cin ^ carry;
`endif

  assign cell_in.a   = a_sr[0];
  assign cell_in.b   = b_sr[0];
  assign cell_in.cin = carry;

  fa_cell u_fa_cell (
    .cell_in  (cell_in),
    .cell_out (cell_out)
  );

  assign out_sum  = res_sr;
  assign out_cout = carry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      msb_cin   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= in_a;
            b_sr     <= in_b;
            carry    <= in_cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
          res_sr <= {cell_out.sum, res_sr[WIDTH-1:1]};
          carry  <= cell_out.carry;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          if (cnt == LAST_BIT) begin
            state     <= DONE;
            out_valid <= 1'b1;
`ifdef SERIAL_ADD_OVF_EN
            msb_cin   <= carry;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed cases plus 1000 random
// operand sets against a transaction-level reference model.
module tb_serial_add_ctrl;

  localparam int W = 8;
  localparam int NRAND = 1000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         out_ovf;
`endif

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
`ifdef SERIAL_ADD_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = adding, 2 = holding a result
  int           m_state = 0;
  int           m_left = 0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf = 1'b0;
  int           m_acc = 0;
  int           m_xfer = 0;
  logic [W:0]   m_tot;

  logic rand_ready = 1'b0;
  logic fixed_ready = 1'b1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_state = 0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_sum", 32'(out_sum), 32'd0);
        chk("rst_out_cout", 32'(out_cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
      end else begin
        chk("mon_in_ready", 32'(in_ready), 32'(m_state == 0));
        chk("mon_out_valid", 32'(out_valid), 32'(m_state == 2));
        chk("mon_busy", 32'(busy), 32'(m_state != 0));
        if (m_state == 2) begin
          chk("mon_out_sum", 32'(out_sum), 32'(m_sum));
          chk("mon_out_cout", 32'(out_cout), 32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
          chk("mon_out_ovf", 32'(out_ovf), 32'(m_ovf));
`endif
        end
        // Predict the effect of the coming rising edge.
        case (m_state)
          0: if (in_valid) begin
            m_tot   = {1'b0, in_a} + {1'b0, in_b} + (W+1)'(in_cin);
            m_sum   = m_tot[W-1:0];
            m_cout  = m_tot[W];
            m_ovf   = (in_a[W-1] == in_b[W-1]) && (m_tot[W-1] != in_a[W-1]);
            m_left  = W;
            m_state = 1;
            m_acc++;
          end
          1: begin
            m_left--;
            if (m_left == 0) m_state = 2;
          end
          default: if (out_ready) begin
            m_state = 0;
            m_xfer++;
          end
        endcase
      end
    end
  endtask

  task automatic ready_driver();
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : fixed_ready;
    end
  endtask

  // Drives one request while idle; returns edges from accept edge to out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output int lat);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
  endtask

  int   lat;
  int   n;
  int   acc0, xfer0;
  logic [W-1:0] hold_sum;
  logic hold_cout;
  logic rdy;

  initial begin
    fork
      monitor();
      ready_driver();
    join_none

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // FF + 01 + 0
    fixed_ready = 1'b1;
    do_op(8'hFF, 8'h01, 1'b0, lat);
    chk("ff01_latency", 32'(lat), 32'd8);
    chk("ff01_sum", 32'(out_sum), 32'h00);
    chk("ff01_cout", 32'(out_cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    chk("ff01_ovf", 32'(out_ovf), 32'd0);
`endif
    @(posedge clk); #1;
    chk("ff01_ready_after", 32'(in_ready), 32'd1);

    // 3C + 5A + 1
    do_op(8'h3C, 8'h5A, 1'b1, lat);
    chk("3c5a_latency", 32'(lat), 32'd8);
    chk("3c5a_sum", 32'(out_sum), 32'h97);
    chk("3c5a_cout", 32'(out_cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("3c5a_ovf", 32'(out_ovf), 32'd1);
`endif
    @(posedge clk); #1;

    // Backpressure: result held for 5 cycles, then a single transfer.
    fixed_ready = 1'b0;
    @(posedge clk); #1;
    do_op(8'hA7, 8'h6E, 1'b0, lat);
    chk("bp_sum", 32'(out_sum), 32'h15);
    chk("bp_cout", 32'(out_cout), 32'd1);
    hold_sum = out_sum;
    hold_cout = out_cout;
    xfer0 = m_xfer;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_sum", 32'(out_sum), 32'(hold_sum));
      chk("bp_hold_cout", 32'(out_cout), 32'(hold_cout));
      chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    fixed_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_one_transfer", 32'(m_xfer - xfer0), 32'd1);

    // Back-to-back with in_valid held high.
    in_a = 8'h10; in_b = 8'h20; in_cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 8'h80; in_b = 8'h80; in_cin = 1'b1;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (out_valid) chk("b2b_first_sum", 32'(out_sum), 32'h30);
      if (in_ready) break;
      chk("b2b_not_accepted", 32'(busy), 32'd1);
    end
    chk("b2b_ready_interval", 32'(n), 32'd9);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_second_accepted", 32'(in_ready), 32'd0);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    chk("b2b_second_latency", 32'(lat), 32'd8);
    chk("b2b_second_sum", 32'(out_sum), 32'h01);
    chk("b2b_second_cout", 32'(out_cout), 32'd1);
    @(posedge clk); #1;

    // Reset while bit 4 is being added.
    in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(8'h01, 8'h01, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd8);
    chk("post_rst_sum", 32'(out_sum), 32'h02);
    chk("post_rst_cout", 32'(out_cout), 32'd0);
    @(posedge clk); #1;

    // Random traffic with random consumer stalls.
    acc0 = m_acc;
    xfer0 = m_xfer;
    rand_ready = 1'b1;
    for (int i = 0; i < NRAND; i++) begin
      in_a = W'($urandom);
      in_b = W'($urandom);
      in_cin = 1'($urandom);
      in_valid = 1'b1;
      n = 0;
      rdy = 1'b0;
      while (!rdy && n < 200) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!rdy) chk("rand_accept_timeout", 32'(n), 32'd0);
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    n = 0;
    while (m_state != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rand_accepted", 32'(m_acc - acc0), 32'(NRAND));
    chk("rand_transferred", 32'(m_xfer - xfer0), 32'(NRAND));
    chk("rand_drained", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
